stream_fifo_param: RTL and testbench
====================================

// Module: stream_fifo_param
// PURPOSE
//   Parametrised synchronous streaming FIFO; next-generation replacement for the fixed FIFOs around dut_system.
//   Adds selectable first-word-fall-through (FWFT) or standard read mode and programmable almost-full/almost-empty flags.
//   Also adds an occupancy count and sticky overflow/underflow error flags.
//   Sits between file-driven bench stimulus / upstream producers and the DUT datapath, one per stream.
// PARAMETERS
//   DATA_WIDTH   32         word width in bits (>=1)
//   DEPTH        64         entries; power of two, >=4; else elaboration error
//   FWFT         1          1 = head word visible on dout while !empty; 0 = standard, dout updates after rd_en
//   AF_THRESH    DEPTH-4    almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH    4          almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//   clock         in   1                      rising-edge clock
//   reset         in   1                      asynchronous, active-high reset
//   wr_en         in   1                      write request
//   din           in   DATA_WIDTH             write data
//   full          out  1                      count == DEPTH
//   almost_full   out  1                      count >= AF_THRESH
//   rd_en         in   1                      read/pop request
//   dout          out  DATA_WIDTH             read data (mode-dependent, see BEHAVIOUR)
//   empty         out  1                      count == 0
//   almost_empty  out  1                      count <= AE_THRESH
//   count         out  $clog2(DEPTH)+1        stored entries, 0..DEPTH
//   overflow      out  1                      sticky: write attempted while full
//   underflow     out  1                      sticky: read attempted while empty
//   clear_err     in   1                      synchronous clear of overflow/underflow
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): rd/wr pointers=0, count=0, empty=1, almost_empty=1,
//     full=0, almost_full=0, overflow=0, underflow=0, dout=0. Storage array not reset. Reset mid-stream discards all data.
//   - Pointers $clog2(DEPTH)+1 bits with wrap bit; index wraps DEPTH-1 -> 0 with no gap or duplicate.
//   - Write accepted at edge iff wr_en && !full (full sampled before the edge). wr_en && full: word dropped, overflow<=1.
//   - Read accepted at edge iff rd_en && !empty. rd_en && empty: no state change, dout held, underflow<=1.
//   - Full blocks writes even with simultaneous accepted read; empty blocks reads even with simultaneous write.
//   - Simultaneous accepted read+write: count unchanged, both pointers advance.
//   - count registered: +1 write only, -1 read only, unchanged otherwise. All four flags decoded from registered count.
//     They update in the same cycle as count, with no combinational path from wr_en/rd_en.
//   - Write latency: word written at edge k -> empty=0 and count updated after edge k.
//   - FWFT=1: while empty=0, dout = oldest stored word. After an accepted read at edge k, dout = next word after edge k.
//     While empty=1, dout is don't-care but must not be X after reset.
//   - FWFT=0: an accepted read at edge k loads the popped word into dout after edge k. dout holds it until the next accepted read.
//   - clear_err at edge clears both sticky flags. If an error occurs at the same edge, the flag is set (error wins).
//   - Assertion (sim only): count never exceeds DEPTH; pointer difference == count.
// TESTING
//   1 Reset: assert reset mid-clock with FIFO half full -> outputs take reset values immediately (async); count=0, empty=1.
//   2 FWFT=1, DEPTH=64: write 0x00000001..0x00000040 -> full=1 at count 64, almost_full from count 60.
//     Then drain with rd_en held -> dout sequence 1..64 in order, empty after 64th pop.
//   3 FWFT=0: write 0xA5A5A5A5 then pulse rd_en -> dout=0xA5A5A5A5 one edge after rd_en, held while rd_en=0.
//   4 Full: 65th write 0xDEADBEEF -> dropped, overflow=1, count stays 64.
//     Then simultaneous rd+wr while full -> read accepted, write dropped, count=63.
//   5 Empty: rd_en at count 0 -> underflow=1, dout unchanged. clear_err together with a new underflow -> underflow stays 1.
//     clear_err alone -> 0.
//   6 Wrap: 200 random-gap transactions with rd/wr both active at count 1..63 -> output stream equals input stream.
//     count is constant on dual ops, and pointers wrap cleanly.

Source files
------------

// File: rtl/stream_fifo_param.sv
// Parametrised streaming FIFO with selectable first-word-fall-through or standard read,
// programmable almost-full/almost-empty thresholds, occupancy count and sticky error flags.
module stream_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter bit FWFT       = 1'b1,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    full,
  output logic                    almost_full,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    empty,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] ptr_t;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo_param: DEPTH must be a power of two and >= 4");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("stream_fifo_param: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo_param: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  ptr_t                  count_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Handshake: wr_en is a request that is taken at the edge only while !full, and rd_en
  // likewise only while !empty; a refused request moves no data and only raises its sticky flag.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Flags decode the registered count only, so none has a path from wr_en/rd_en.
  assign count        = count_q;
  assign full         = (count_q == ptr_t'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= ptr_t'(AF_THRESH));
  assign almost_empty = (count_q <= ptr_t'(AE_THRESH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ptr_t'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ptr_t'(1);
        2'b01:   count_q <= count_q - ptr_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= din;
  end

  // A new error at the same edge as clear_err wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en && full)  || (overflow  && !clear_err);
      underflow <= (rd_en && empty) || (underflow && !clear_err);
    end
  end

  if (FWFT) begin : g_fwft
    // Storage is not reset, so the head is masked to zero while empty.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset)       dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr[AW-1:0]];
    end
    assign dout = dout_q;
  end

  a_count_bound : assert property (@(posedge clock) disable iff (reset)
    count_q <= ptr_t'(DEPTH));
  a_ptr_diff : assert property (@(posedge clock) disable iff (reset)
    (ptr_t'(wr_ptr - rd_ptr) == count_q));

endmodule

// File: tb/tb_stream_fifo_param.sv
// Bench driving one FWFT and one standard-mode FIFO with identical stimulus against a
// shared occupancy model and an expected-data queue.
module tb_stream_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] din = '0;

  logic          full_f, af_f, empty_f, ae_f, ovf_f, udf_f;
  logic [DW-1:0] dout_f;
  logic [CW-1:0] count_f;
  logic          full_s, af_s, empty_s, ae_s, ovf_s, udf_s;
  logic [DW-1:0] dout_s;
  logic [CW-1:0] count_s;

  stream_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(din), .full(full_f),
    .almost_full(af_f), .rd_en(rd_en), .dout(dout_f), .empty(empty_f),
    .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(udf_f),
    .clear_err(clear_err)
  );

  stream_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
    .clock(clock), .reset(reset), .wr_en(wr_en), .din(din), .full(full_s),
    .almost_full(af_s), .rd_en(rd_en), .dout(dout_s), .empty(empty_s),
    .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(udf_s),
    .clear_err(clear_err)
  );

  // scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            m_count = 0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  logic [DW-1:0] s_dout = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count_f", 64'(count_f), 64'(m_count));
    check("count_s", 64'(count_s), 64'(m_count));
    check("empty_f", 64'(empty_f), 64'(m_count == 0));
    check("empty_s", 64'(empty_s), 64'(m_count == 0));
    check("full_f",  64'(full_f),  64'(m_count == DEPTH));
    check("full_s",  64'(full_s),  64'(m_count == DEPTH));
    check("af_f",    64'(af_f),    64'(m_count >= DEPTH - 4));
    check("af_s",    64'(af_s),    64'(m_count >= DEPTH - 4));
    check("ae_f",    64'(ae_f),    64'(m_count <= 4));
    check("ae_s",    64'(ae_s),    64'(m_count <= 4));
    check("ovf_f",   64'(ovf_f),   64'(m_ovf));
    check("ovf_s",   64'(ovf_s),   64'(m_ovf));
    check("udf_f",   64'(udf_f),   64'(m_udf));
    check("udf_s",   64'(udf_s),   64'(m_udf));
    check("dout_s",  64'(dout_s),  64'(s_dout));
    if (m_count != 0) check("dout_f_head", 64'(dout_f), 64'(exp_q[0]));
  endtask

  // driver: one clock of stimulus, called #1 after a rising edge
  task automatic op(input bit w, input bit r, input logic [DW-1:0] d, input bit clr);
    bit            wr_ok;
    bit            rd_ok;
    logic [DW-1:0] popped;
    wr_en = w; rd_en = r; din = d; clear_err = clr;
    wr_ok  = w && (m_count != DEPTH);
    rd_ok  = r && (m_count != 0);
    popped = '0;
    if (rd_ok) begin
      popped = exp_q.pop_front();
      check("dout_f_pop", 64'(dout_f), 64'(popped));
    end
    if (wr_ok) exp_q.push_back(d);
    @(posedge clock); #1;
    wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
    if (rd_ok) s_dout = popped;
    m_ovf   = (w && m_count == DEPTH) || (m_ovf && !clr);
    m_udf   = (r && m_count == 0)     || (m_udf && !clr);
    m_count = m_count + int'(wr_ok) - int'(rd_ok);
    check_all();
  endtask

  task automatic drain();
    while (m_count > 0) op(1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    bit w, r;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_all();

    // async reset mid-stream with the FIFO half full
    for (int i = 0; i < DEPTH / 2; i++) op(1'b1, 1'b0, $urandom, 1'b0);
    #3 reset = 1'b1;
    #1;
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; s_dout = '0;
    check_all();
    check("dout_f_rst", 64'(dout_f), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    check_all();

    // fill 1..64, then drain in order
    for (int i = 1; i <= DEPTH; i++) op(1'b1, 1'b0, DW'(i), 1'b0);
    drain();

    // standard-mode read latency and hold
    op(1'b1, 1'b0, 32'hA5A5_A5A5, 1'b0);
    op(1'b0, 1'b1, '0, 1'b0);
    check("std_a5", 64'(dout_s), 64'h0000_0000_A5A5_A5A5);
    op(1'b0, 1'b0, '0, 1'b0);
    op(1'b0, 1'b0, '0, 1'b0);

    // overflow, then simultaneous read+write while full
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, $urandom, 1'b0);
    op(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    op(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    drain();

    // underflow, clear colliding with a new error, plain clear
    op(1'b0, 1'b1, '0, 1'b0);
    op(1'b0, 1'b1, '0, 1'b1);
    op(1'b0, 1'b0, '0, 1'b1);

    // random traffic across many pointer wraps
    for (int i = 0; i < DEPTH / 2; i++) op(1'b1, 1'b0, $urandom, 1'b0);
    for (int i = 0; i < 200; i++) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (m_count == 0) r = 1'b0;
      if (m_count == DEPTH) w = 1'b0;
      op(w, r, $urandom, 1'b0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
